// File: rtl/tape_in_fsk_decoder_if.sv
// Sample stream into the cassette FSK decoder and the decoded bit stream out of it.
interface tape_in_fsk_decoder_if;
    logic       sample_valid;
    logic [7:0] unsigned_audio;
    logic       sq_out;
    logic       carrier;
    logic       bit_valid;
    logic       bit_out;

    // Audio source side: drives samples, observes decoder results.
    modport master (
        output sample_valid,
        output unsigned_audio,
        input  sq_out,
        input  carrier,
        input  bit_valid,
        input  bit_out
    );

    // Decoder side: consumes samples, produces slicer level, carrier and bits.
    modport slave (
        input  sample_valid,
        input  unsigned_audio,
        output sq_out,
        output carrier,
        output bit_valid,
        output bit_out
    );
endinterface

// File: rtl/tape_in_fsk_decoder.sv
// Cassette read path: slices 8-bit tape audio with hysteresis, times each
// rising-edge-to-rising-edge cycle and turns 1200/2400 Hz cycles into FM-7 bits
// (one long cycle = 0, two short cycles = 1) while the motor relay is on.
module tape_in_fsk_decoder #(
    parameter logic [7:0] HI_TH     = 8'd144,
    parameter logic [7:0] LO_TH     = 8'd112,
    parameter int         SPLIT     = 30,
    parameter int         MIN_PER   = 12,
    parameter int         MAX_PER   = 56,
    parameter int         CARRIER_N = 16
) (
    input  logic                  CLKSYS,
    input  logic                  RESET,
    input  logic                  motor,
    tape_in_fsk_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        WAIT_EDGE,
        MEASURE,
        HALF_ONE
    } state_t;

    localparam int                GOOD_W      = $clog2(CARRIER_N + 1);
    localparam logic [7:0]        SPLIT_P     = 8'(SPLIT);
    localparam logic [7:0]        MIN_P       = 8'(MIN_PER);
    localparam logic [7:0]        MAX_P       = 8'(MAX_PER);
    // A non-edge sample at this count means any later edge would exceed MAX_PER.
    localparam logic [7:0]        TIMEOUT_CNT = 8'(MAX_PER - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX    = GOOD_W'(CARRIER_N);

    state_t            state_q, state_d;
    logic              sq_q, sq_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              carrier_q, carrier_d;
    logic              bit_valid_q, bit_valid_d;
    logic              bit_out_q, bit_out_d;

    logic              next_sq;
    logic              rise;
    logic [7:0]        period;
    logic              is_short;
    logic              is_invalid;
    logic [GOOD_W-1:0] good_inc;

    // Hysteresis slicer: set at or above HI_TH, clear at or below LO_TH, else hold.
    always_comb begin
        next_sq = sq_q;
        if (bus.unsigned_audio >= HI_TH) begin
            next_sq = 1'b1;
        end else if (bus.unsigned_audio <= LO_TH) begin
            next_sq = 1'b0;
        end
    end

    // Outside WAIT_EDGE the timeout keeps cnt below MAX_PER, so cnt+1 cannot wrap
    // where the period is actually used.
    assign rise       = !sq_q && next_sq;
    assign period     = cnt_q + 8'd1;
    assign is_short   = period < SPLIT_P;
    assign is_invalid = (period < MIN_P) || (period > MAX_P);
    assign good_inc   = (good_q == GOOD_MAX) ? good_q : good_q + 1'b1;

    // Next-state logic: slicer, period counter, cycle classifier, carrier and bit emission.
    always_comb begin
        // NOTE: every _d signal takes its hold value first, so no path leaves it unassigned (no latch).
        state_d     = state_q;
        sq_d        = sq_q;
        cnt_d       = cnt_q;
        good_d      = good_q;
        carrier_d   = carrier_q;
        bit_valid_d = 1'b0;
        bit_out_d   = bit_out_q;

        if (!motor) begin
            // Relay off: idle everything and forget any half-received bit.
            state_d   = WAIT_EDGE;
            sq_d      = 1'b0;
            cnt_d     = '0;
            good_d    = '0;
            carrier_d = 1'b0;
            bit_out_d = 1'b0;
        end else if (bus.sample_valid) begin
            sq_d = next_sq;
            if (rise) begin
                cnt_d = '0;
                if (state_q == WAIT_EDGE) begin
                    // First edge only opens a measurement window.
                    state_d = MEASURE;
                end else if (is_invalid) begin
                    // Glitch or dropout: restart measuring from this edge.
                    good_d    = '0;
                    carrier_d = 1'b0;
                    state_d   = MEASURE;
                end else begin
                    good_d    = good_inc;
                    carrier_d = (good_inc == GOOD_MAX);
                    if (state_q == HALF_ONE) begin
                        // Second short completes a 1; a long here orphans the half and reads as 0.
                        bit_valid_d = 1'b1;
                        bit_out_d   = is_short;
                        state_d     = MEASURE;
                    end else if (is_short) begin
                        state_d = HALF_ONE;
                    end else begin
                        bit_valid_d = 1'b1;
                        bit_out_d   = 1'b0;
                    end
                end
            end else begin
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if ((state_q != WAIT_EDGE) && (cnt_q == TIMEOUT_CNT)) begin
                    good_d    = '0;
                    carrier_d = 1'b0;
                    state_d   = WAIT_EDGE;
                end
            end
        end
    end

    // State and registered outputs with synchronous active-high reset.
    always_ff @(posedge CLKSYS) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (RESET) begin
            state_q     <= WAIT_EDGE;
            sq_q        <= 1'b0;
            cnt_q       <= '0;
            good_q      <= '0;
            carrier_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sq_q        <= sq_d;
            cnt_q       <= cnt_d;
            good_q      <= good_d;
            carrier_q   <= carrier_d;
            bit_valid_q <= bit_valid_d;
            bit_out_q   <= bit_out_d;
        end
    end

    assign bus.sq_out    = sq_q;
    assign bus.carrier   = carrier_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.bit_out   = bit_out_q;

endmodule

// File: tb/tb_tape_in_fsk_decoder.sv
// Directed bench for the cassette FSK decoder: square-wave cycles of chosen
// periods are fed one sample per two clocks and decoded bits are collected.
module tb_tape_in_fsk_decoder;

    logic CLKSYS = 1'b0;
    logic RESET;
    logic motor;

    tape_in_fsk_decoder_if bus ();

    tape_in_fsk_decoder dut (
        .CLKSYS (CLKSYS),
        .RESET  (RESET),
        .motor  (motor),
        .bus    (bus)
    );

    always #5 CLKSYS = ~CLKSYS;

    int checks      = 0;
    int errors      = 0;
    int stray       = 0;
    int idle_pulses = 0;
    bit bits_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Collected bits packed oldest-first into the MSB end.
    function automatic int pack_bits();
        int r = 0;
        foreach (bits_q[i]) r = (r << 1) | int'(bits_q[i]);
        return r;
    endfunction

    // One strobed sample followed by one idle clock; called and returns at a negedge.
    task automatic samp(input logic [7:0] v, input bit allow_pulse);
        logic bv, bo;
        bus.sample_valid   = 1'b1;
        bus.unsigned_audio = v;
        @(negedge CLKSYS);
        bus.sample_valid = 1'b0;
        bv = bus.bit_valid;
        bo = bus.bit_out;
        if (bv) begin
            bits_q.push_back(bo);
            if (!allow_pulse) stray++;
        end
        @(negedge CLKSYS);
        if (bus.bit_valid) idle_pulses++;
    endtask

    // One square cycle: high half first, so the first sample is the rising edge.
    task automatic send_cycle(input int p);
        for (int i = 0; i < p; i++) samp((i < p / 2) ? 8'hFF : 8'h00, i == 0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        @(negedge CLKSYS);
        RESET = 1'b0;
        bits_q.delete();
        stray = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        RESET = 1'b1;
        motor = 1'b1;
        bus.sample_valid   = 1'b0;
        bus.unsigned_audio = 8'h80;
        @(negedge CLKSYS);
        @(negedge CLKSYS);
        RESET = 1'b0;
        check("rst_sq", bus.sq_out, 0);
        check("rst_carrier", bus.carrier, 0);
        check("rst_bv", bus.bit_valid, 0);
        check("rst_bo", bus.bit_out, 0);

        // Long cycles: 0 per cycle after the first edge, carrier on 16th valid cycle.
        send_cycle(40);
        check("long_first_edge_nobit", bits_q.size(), 0);
        for (int c = 2; c <= 16; c++) send_cycle(40);
        check("long_carrier_at15", bus.carrier, 0);
        send_cycle(40);
        check("long_carrier_at16", bus.carrier, 1);
        for (int c = 18; c <= 20; c++) send_cycle(40);
        check("long_count", bits_q.size(), 19);
        check("long_bits", pack_bits(), 0);
        check("long_stray", stray, 0);

        // Short cycles: one 1 per pair of shorts.
        do_reset();
        for (int c = 0; c < 8; c++) send_cycle(20);
        samp(8'hFF, 1'b1);
        check("short_count", bits_q.size(), 4);
        check("short_bits", pack_bits(), 4'b1111);
        check("short_stray", stray, 0);
        check("short_sq_hi", bus.sq_out, 1);
        check("short_bo_hi", bus.bit_out, 1);

        // Reset mid-stream clears outputs on the next cycle.
        RESET = 1'b1;
        @(negedge CLKSYS);
        RESET = 1'b0;
        check("midrst_sq", bus.sq_out, 0);
        check("midrst_bo", bus.bit_out, 0);
        check("midrst_bv", bus.bit_valid, 0);
        check("midrst_carrier", bus.carrier, 0);

        // Mixed L S S L S L -> 0 1 0 0 (orphan short dropped).
        do_reset();
        send_cycle(40); send_cycle(20); send_cycle(20);
        send_cycle(40); send_cycle(20); send_cycle(40);
        samp(8'hFF, 1'b1);
        check("mixed_count", bits_q.size(), 4);
        check("mixed_bits", pack_bits(), 4'b0100);
        check("mixed_stray", stray, 0);

        // Period boundaries: 12,12 -> 1; 29,29 -> 1; 30 -> 0; 56 -> 0; 11 glitch; 40 -> 0.
        do_reset();
        send_cycle(40); send_cycle(12); send_cycle(12); send_cycle(29); send_cycle(29);
        send_cycle(30); send_cycle(56); send_cycle(11); send_cycle(40);
        samp(8'hFF, 1'b1);
        check("bound_count", bits_q.size(), 6);
        check("bound_bits", pack_bits(), 6'b011000);
        check("bound_stray", stray, 0);

        // Hysteresis band holds the level; thresholds are inclusive.
        do_reset();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            samp((i % 2 == 0) ? 8'h80 : 8'h88, 1'b0);
            if (bus.sq_out) n++;
        end
        check("hyst_band_sq", n, 0);
        samp(8'hFF, 1'b1);
        check("hyst_ff_sq", bus.sq_out, 1);
        samp(8'h00, 1'b0);
        check("hyst_00_sq", bus.sq_out, 0);
        samp(8'd143, 1'b0);
        check("hyst_143_sq", bus.sq_out, 0);
        samp(8'd144, 1'b1);
        check("hyst_144_sq", bus.sq_out, 1);
        samp(8'd113, 1'b0);
        check("hyst_113_sq", bus.sq_out, 1);
        samp(8'd112, 1'b0);
        check("hyst_112_sq", bus.sq_out, 0);
        check("hyst_nobits", bits_q.size(), 0);
        check("hyst_carrier", bus.carrier, 0);

        // Timeout: 60 samples without an edge drops carrier; next edge emits nothing.
        do_reset();
        for (int c = 0; c < 18; c++) send_cycle(40);
        check("to_carrier_on", bus.carrier, 1);
        samp(8'hFF, 1'b1);
        for (int i = 0; i < 50; i++) samp(8'hFF, 1'b0);
        check("to_carrier_held", bus.carrier, 1);
        for (int i = 0; i < 10; i++) samp(8'hFF, 1'b0);
        check("to_carrier_off", bus.carrier, 0);
        n = bits_q.size();
        for (int i = 0; i < 20; i++) samp(8'h00, 1'b0);
        samp(8'hFF, 1'b1);
        check("to_edge_nobit", bits_q.size(), n);
        check("to_stray", stray, 0);

        // Glitch: a 6-sample cycle clears carrier without a bit, then measuring restarts.
        do_reset();
        for (int c = 0; c < 18; c++) send_cycle(40);
        check("gl_carrier_on", bus.carrier, 1);
        samp(8'hFF, 1'b1);
        n = bits_q.size();
        for (int i = 0; i < 2; i++) samp(8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) samp(8'h00, 1'b0);
        samp(8'hFF, 1'b1);
        check("gl_carrier_off", bus.carrier, 0);
        check("gl_nobit", bits_q.size(), n);
        for (int i = 0; i < 19; i++) samp(8'hFF, 1'b0);
        for (int i = 0; i < 20; i++) samp(8'h00, 1'b0);
        samp(8'hFF, 1'b1);
        check("gl_restart_count", bits_q.size(), n + 1);
        check("gl_restart_bit", bits_q[bits_q.size() - 1], 0);
        check("gl_stray", stray, 0);

        // Motor drop in HALF_ONE discards the pending half.
        do_reset();
        send_cycle(40); send_cycle(20);
        samp(8'hFF, 1'b1);
        check("mot_pre_bits", pack_bits(), 0);
        check("mot_pre_count", bits_q.size(), 1);
        motor = 1'b0;
        @(negedge CLKSYS);
        check("mot_off_sq", bus.sq_out, 0);
        for (int i = 0; i < 3; i++) samp(8'hFF, 1'b0);
        check("mot_off_sq_held", bus.sq_out, 0);
        check("mot_off_carrier", bus.carrier, 0);
        motor = 1'b1;
        bits_q.delete();
        send_cycle(40);
        check("mot_first_edge", bits_q.size(), 0);
        send_cycle(40);
        check("mot_second_count", bits_q.size(), 1);
        check("mot_second_bit", pack_bits(), 0);
        send_cycle(40);
        check("mot_third_count", bits_q.size(), 2);
        check("mot_stray", stray, 0);

        check("idle_pulses", idle_pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
